// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: single outstanding data-bus transaction with byte-lane
// steering, load extension, misalignment detection and orphan absorption.
module riscv_lsu (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_req_o,
   output logic        lsu_misaligned_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2
   } state_t;

   // Undefined size codes fall through to signed byte.
   function automatic logic size_is_half(input logic [2:0] size);
      return (size == 3'b001) || (size == 3'b101);
   endfunction

   function automatic logic size_is_word(input logic [2:0] size);
      return size == 3'b010;
   endfunction

   function automatic logic size_is_unsigned(input logic [2:0] size);
      return (size == 3'b100) || (size == 3'b101);
   endfunction

   state_t      state_reg, state_next;
   logic        orphan_reg, orphan_next;

   logic [29:0] waddr_reg;
   logic        we_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic [2:0]  size_reg;
   logic [1:0]  offset_reg;

   logic        in_half;
   logic        in_word;
   logic        in_misaligned;
   logic [3:0]  in_be;
   logic [31:0] in_wdata;
   logic        issue;
   logic        completion;

   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;

   assign in_half       = size_is_half(lsu_size_i);
   assign in_word       = size_is_word(lsu_size_i);
   assign in_misaligned = (in_half && lsu_addr_i[0]) ||
                          (in_word && (lsu_addr_i[1:0] != 2'b00));

   always_comb begin
      if (in_word) begin
         in_be = 4'b1111;
      end else if (in_half) begin
         in_be = 4'b0011 << lsu_addr_i[1:0];
      end else begin
         in_be = 4'b0001 << lsu_addr_i[1:0];
      end
   end

   // Replicate the store operand so every enabled lane carries the right byte.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign in_wdata[8*gi +: 8] = in_word ? lsu_data_i[8*gi +: 8] :
                                      in_half ? lsu_data_i[8*(gi%2) +: 8] :
                                                lsu_data_i[7:0];
      end
   endgenerate

   assign issue      = (state_reg == IDLE) && lsu_req_i && !in_misaligned;
   assign completion = (state_reg == WAIT_RVALID) && data_rvalid_i &&
                       lsu_req_i && !orphan_reg;

   always_comb begin
      load_byte = data_rdata_i[{offset_reg, 3'b000} +: 8];
      load_half = offset_reg[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
      if (size_is_word(size_reg)) begin
         load_value = data_rdata_i;
      end else if (size_is_half(size_reg)) begin
         load_value = size_is_unsigned(size_reg) ? {16'h0000, load_half}
                                                 : {{16{load_half[15]}}, load_half};
      end else begin
         load_value = size_is_unsigned(size_reg) ? {24'h000000, load_byte}
                                                 : {{24{load_byte[7]}}, load_byte};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg  <= IDLE;
         orphan_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         orphan_reg <= orphan_next;
      end
   end

   // Request fields are captured once at issue so the bus stays stable until grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         waddr_reg  <= 30'd0;
         we_reg     <= 1'b0;
         be_reg     <= 4'b0000;
         wdata_reg  <= 32'd0;
         size_reg   <= 3'b000;
         offset_reg <= 2'b00;
      end else if (issue) begin
         waddr_reg  <= lsu_addr_i[31:2];
         we_reg     <= lsu_we_i;
         be_reg     <= in_be;
         wdata_reg  <= in_wdata;
         size_reg   <= lsu_size_i;
         offset_reg <= lsu_addr_i[1:0];
      end
   end

   always_comb begin
      state_next  = state_reg;
      orphan_next = orphan_reg;
      case (state_reg)
         IDLE: begin
            orphan_next = 1'b0;
            if (issue) begin
               state_next = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            orphan_next = orphan_reg | ~lsu_req_i;
            if (data_gnt_i) begin
               state_next = WAIT_RVALID;
            end
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) begin
               state_next  = IDLE;
               orphan_next = 1'b0;
            end else begin
               orphan_next = orphan_reg | ~lsu_req_i;
            end
         end
         default: begin
            state_next  = IDLE;
            orphan_next = 1'b0;
         end
      endcase
   end

   // Everything is forced low while reset is held, including the combinational issue path.
   always_comb begin
      lsu_data_o       = 32'd0;
      lsu_stall_req_o  = 1'b0;
      lsu_misaligned_o = 1'b0;
      data_req_o       = 1'b0;
      data_we_o        = 1'b0;
      data_be_o        = 4'b0000;
      data_addr_o      = 32'd0;
      data_wdata_o     = 32'd0;
      if (!rst_i) begin
         case (state_reg)
            IDLE: begin
               if (lsu_req_i) begin
                  if (in_misaligned) begin
                     lsu_misaligned_o = 1'b1;
                  end else begin
                     data_req_o      = 1'b1;
                     data_we_o       = lsu_we_i;
                     data_be_o       = in_be;
                     data_addr_o     = {lsu_addr_i[31:2], 2'b00};
                     data_wdata_o    = in_wdata;
                     lsu_stall_req_o = 1'b1;
                  end
               end
            end
            WAIT_GNT: begin
               data_req_o      = 1'b1;
               data_we_o       = we_reg;
               data_be_o       = be_reg;
               data_addr_o     = {waddr_reg, 2'b00};
               data_wdata_o    = wdata_reg;
               lsu_stall_req_o = lsu_req_i;
            end
            WAIT_RVALID: begin
               lsu_stall_req_o = lsu_req_i && !completion;
               if (completion && !we_reg) begin
                  lsu_data_o = load_value;
               end
            end
            default: begin
               lsu_stall_req_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: vector table of single accesses with a completion
// scoreboard, plus hand-written wait-state, orphan and reset sequences.
module tb_riscv_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_req_o;
   logic        lsu_misaligned_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   always #5 clk_i = ~clk_i;

   riscv_lsu dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .lsu_req_i       (lsu_req_i),
      .lsu_we_i        (lsu_we_i),
      .lsu_size_i      (lsu_size_i),
      .lsu_addr_i      (lsu_addr_i),
      .lsu_data_i      (lsu_data_i),
      .lsu_data_o      (lsu_data_o),
      .lsu_stall_req_o (lsu_stall_req_o),
      .lsu_misaligned_o(lsu_misaligned_o),
      .data_req_o      (data_req_o),
      .data_we_o       (data_we_o),
      .data_be_o       (data_be_o),
      .data_addr_o     (data_addr_o),
      .data_wdata_o    (data_wdata_o),
      .data_gnt_i      (data_gnt_i),
      .data_rvalid_i   (data_rvalid_i),
      .data_rdata_i    (data_rdata_i)
   );

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] waddr;
      logic [31:0] wexp;
      logic [31:0] ld;
      logic        mis;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] ld;
   } exp_t;

   vec_t vecs [15];
   exp_t sb [$];
   exp_t e;
   int   n_applied = 0;
   int   n_miss    = 0;
   int   req_cnt;
   int   stall_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic drive_idle();
      lsu_req_i     = 1'b0;
      lsu_we_i      = 1'b0;
      lsu_size_i    = 3'b000;
      lsu_addr_i    = 32'd0;
      lsu_data_i    = 32'd0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
      lsu_req_i  = 1'b1;
      lsu_we_i   = we;
      lsu_size_i = size;
      lsu_addr_i = addr;
      lsu_data_i = wdata;
   endtask

   task automatic pop_check(input string name);
      if (sb.size() == 0) begin
         chk({name, "_sb_underflow"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         if (!e.we) chk({name, "_ldata"}, lsu_data_o, e.ld);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          we    size    addr          wdata         rdata         be       waddr         wexp          ld            mis
      vecs[0]  = '{1'b0, 3'b000, 32'h00000103, 32'h00000000, 32'h80112233, 4'b1000, 32'h00000100, 32'h00000000, 32'hFFFFFF80, 1'b0};
      vecs[1]  = '{1'b0, 3'b100, 32'h00000103, 32'h00000000, 32'h80112233, 4'b1000, 32'h00000100, 32'h00000000, 32'h00000080, 1'b0};
      vecs[2]  = '{1'b0, 3'b001, 32'h00000102, 32'h00000000, 32'h80112233, 4'b1100, 32'h00000100, 32'h00000000, 32'hFFFF8011, 1'b0};
      vecs[3]  = '{1'b0, 3'b101, 32'h00000100, 32'h00000000, 32'h80112233, 4'b0011, 32'h00000100, 32'h00000000, 32'h00002233, 1'b0};
      vecs[4]  = '{1'b0, 3'b010, 32'h00000104, 32'h00000000, 32'hDEADBEEF, 4'b1111, 32'h00000104, 32'h00000000, 32'hDEADBEEF, 1'b0};
      vecs[5]  = '{1'b0, 3'b000, 32'h00000201, 32'h00000000, 32'h00007F00, 4'b0010, 32'h00000200, 32'h00000000, 32'h0000007F, 1'b0};
      vecs[6]  = '{1'b0, 3'b011, 32'h00000302, 32'h00000000, 32'h00AB0000, 4'b0100, 32'h00000300, 32'h00000000, 32'hFFFFFFAB, 1'b0};
      vecs[7]  = '{1'b0, 3'b110, 32'h00000301, 32'h00000000, 32'h0000C300, 4'b0010, 32'h00000300, 32'h00000000, 32'hFFFFFFC3, 1'b0};
      vecs[8]  = '{1'b1, 3'b001, 32'h00000202, 32'h1234ABCD, 32'h00000000, 4'b1100, 32'h00000200, 32'hABCDABCD, 32'h00000000, 1'b0};
      vecs[9]  = '{1'b1, 3'b000, 32'h00000001, 32'h000000A5, 32'h00000000, 4'b0010, 32'h00000000, 32'hA5A5A5A5, 32'h00000000, 1'b0};
      vecs[10] = '{1'b1, 3'b010, 32'h00000008, 32'hCAFEF00D, 32'h00000000, 4'b1111, 32'h00000008, 32'hCAFEF00D, 32'h00000000, 1'b0};
      vecs[11] = '{1'b0, 3'b010, 32'h00000101, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[12] = '{1'b0, 3'b001, 32'h00000003, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[13] = '{1'b1, 3'b010, 32'h000000FE, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[14] = '{1'b0, 3'b101, 32'h00000005, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};

      // Reset held with a live aligned request: every output must stay low.
      drive_idle();
      rst_i = 1'b1;
      drive_req(1'b1, 3'b010, 32'h00000040, 32'h12345678);
      data_gnt_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_stall", lsu_stall_req_o, 1'b0);
      chk("rst_mis", lsu_misaligned_o, 1'b0);
      chk("rst_req", data_req_o, 1'b0);
      chk("rst_we", data_we_o, 1'b0);
      chk("rst_be", data_be_o, 4'b0000);
      chk("rst_addr", data_addr_o, 32'd0);
      chk("rst_wdata", data_wdata_o, 32'd0);
      chk("rst_ldata", lsu_data_o, 32'd0);
      next_cycle();
      rst_i = 1'b0;
      drive_idle();

      // Table: zero-wait accesses (gnt at issue, rvalid next cycle) and misaligned rejects.
      for (int i = 0; i < $size(vecs); i++) begin
         next_cycle();
         drive_req(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         data_gnt_i = 1'b1;
         @(negedge clk_i);
         if (vecs[i].mis) begin
            chk($sformatf("v%0d_mis", i), lsu_misaligned_o, 1'b1);
            chk($sformatf("v%0d_mis_req", i), data_req_o, 1'b0);
            chk($sformatf("v%0d_mis_stall", i), lsu_stall_req_o, 1'b0);
            next_cycle();
            drive_idle();
            @(negedge clk_i);
            chk($sformatf("v%0d_mis_1cyc", i), lsu_misaligned_o, 1'b0);
         end else begin
            chk($sformatf("v%0d_req", i), data_req_o, 1'b1);
            chk($sformatf("v%0d_we", i), data_we_o, vecs[i].we);
            chk($sformatf("v%0d_be", i), data_be_o, vecs[i].be);
            chk($sformatf("v%0d_addr", i), data_addr_o, vecs[i].waddr);
            if (vecs[i].we) chk($sformatf("v%0d_wdata", i), data_wdata_o, vecs[i].wexp);
            chk($sformatf("v%0d_stall_issue", i), lsu_stall_req_o, 1'b1);
            sb.push_back('{vecs[i].we, vecs[i].ld});
            next_cycle();
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b1;
            data_rdata_i  = vecs[i].rdata;
            @(negedge clk_i);
            chk($sformatf("v%0d_stall_done", i), lsu_stall_req_o, 1'b0);
            chk($sformatf("v%0d_req_done", i), data_req_o, 1'b0);
            pop_check($sformatf("v%0d", i));
            next_cycle();
            drive_idle();
            @(negedge clk_i);
            chk($sformatf("v%0d_ldata_after", i), lsu_data_o, 32'd0);
         end
      end

      // LH with gnt withheld three cycles, then one empty wait before rvalid.
      next_cycle();
      drive_req(1'b0, 3'b001, 32'h00000002, 32'd0);
      data_rdata_i = 32'h8001FFFF;
      req_cnt   = 0;
      stall_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         data_gnt_i    = (c == 3);
         data_rvalid_i = (c == 5);
         lsu_req_i     = (c <= 5);
         @(negedge clk_i);
         if (c == 0) sb.push_back('{1'b0, 32'hFFFF8001});
         if (data_req_o) begin
            req_cnt++;
            chk($sformatf("lh_addr_c%0d", c), data_addr_o, 32'h00000000);
         end
         if (lsu_stall_req_o) stall_cnt++;
         if (c == 5) pop_check("lh_wait");
         next_cycle();
      end
      chk("lh_req_cycles", req_cnt, 32'd4);
      chk("lh_stall_cycles", stall_cnt, 32'd5);
      drive_idle();

      // SW orphaned in WAIT_GNT; a new LW arriving meanwhile waits for the orphan to drain.
      next_cycle();
      drive_req(1'b1, 3'b010, 32'h00000040, 32'h11223344);
      @(negedge clk_i);
      chk("orph_issue_stall", lsu_stall_req_o, 1'b1);
      next_cycle();
      lsu_req_i = 1'b0;
      @(negedge clk_i);
      chk("orph_hold_req", data_req_o, 1'b1);
      chk("orph_hold_addr", data_addr_o, 32'h00000040);
      chk("orph_hold_wdata", data_wdata_o, 32'h11223344);
      chk("orph_stall0", lsu_stall_req_o, 1'b0);
      next_cycle();
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("orph_gnt_req", data_req_o, 1'b1);
      chk("orph_stall1", lsu_stall_req_o, 1'b0);
      next_cycle();
      data_gnt_i = 1'b0;
      @(negedge clk_i);
      chk("orph_wait_req", data_req_o, 1'b0);
      chk("orph_stall2", lsu_stall_req_o, 1'b0);
      next_cycle();
      drive_req(1'b0, 3'b010, 32'h00000080, 32'd0);
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'hFFFFFFFF;
      @(negedge clk_i);
      chk("orph_absorb_ldata", lsu_data_o, 32'd0);
      chk("orph_absorb_stall", lsu_stall_req_o, 1'b1);
      chk("orph_absorb_req", data_req_o, 1'b0);
      next_cycle();
      data_rvalid_i = 1'b0;
      data_gnt_i    = 1'b1;
      @(negedge clk_i);
      chk("orph_new_req", data_req_o, 1'b1);
      chk("orph_new_addr", data_addr_o, 32'h00000080);
      chk("orph_new_stall", lsu_stall_req_o, 1'b1);
      sb.push_back('{1'b0, 32'h55AA55AA});
      next_cycle();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h55AA55AA;
      @(negedge clk_i);
      chk("orph_new_stall_done", lsu_stall_req_o, 1'b0);
      pop_check("orph_new");
      next_cycle();
      drive_idle();

      // Reset during WAIT_RVALID, then a late rvalid that must be ignored.
      next_cycle();
      drive_req(1'b0, 3'b010, 32'h00000020, 32'd0);
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("rstmid_issue", data_req_o, 1'b1);
      next_cycle();
      data_gnt_i = 1'b0;
      rst_i      = 1'b1;
      @(negedge clk_i);
      chk("rstmid_stall", lsu_stall_req_o, 1'b0);
      chk("rstmid_req", data_req_o, 1'b0);
      chk("rstmid_be", data_be_o, 4'b0000);
      chk("rstmid_addr", data_addr_o, 32'd0);
      chk("rstmid_ldata", lsu_data_o, 32'd0);
      next_cycle();
      rst_i = 1'b0;
      drive_idle();
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'hFFFFFFFF;
      data_gnt_i    = 1'b1;
      @(negedge clk_i);
      chk("late_rvalid_ldata", lsu_data_o, 32'd0);
      chk("late_rvalid_stall", lsu_stall_req_o, 1'b0);
      chk("stray_gnt_req", data_req_o, 1'b0);
      next_cycle();
      drive_idle();
      drive_req(1'b0, 3'b010, 32'h00000010, 32'd0);
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("post_rst_req", data_req_o, 1'b1);
      chk("post_rst_addr", data_addr_o, 32'h00000010);
      chk("post_rst_be", data_be_o, 4'b1111);
      chk("post_rst_stall", lsu_stall_req_o, 1'b1);
      sb.push_back('{1'b0, 32'h0BADF00D});
      next_cycle();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h0BADF00D;
      @(negedge clk_i);
      chk("post_rst_stall_done", lsu_stall_req_o, 1'b0);
      pop_check("post_rst");
      next_cycle();
      drive_idle();

      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
